// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RV immediate decoder feeding a 2-entry valid/ready output buffer
module imm_gen_pipe #(
  parameter int XLEN          = 64,
  parameter int TAG_W         = 8,
  parameter bit LEGACY_BSHIFT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ins,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  logic [31:0]             raw_imm;
  logic                    is_bj;
  logic signed [XLEN-1:0]  wide_imm;
  logic [XLEN-1:0]         dec_imm;
  logic [2:0]              dec_fmt;

  always_comb begin
    raw_imm = '0;
    dec_fmt = FMT_NONE;
    is_bj   = 1'b0;
    case (in_ins[6:0])
      7'b0010011: begin
        // funct3 001/101 are the shifts; their immediate is an unsigned amount
        if (in_ins[13:12] == 2'b01) begin
          raw_imm = (XLEN == 64) ? {26'b0, in_ins[25:20]} : {27'b0, in_ins[24:20]};
          dec_fmt = FMT_SHAMT;
        end else begin
          raw_imm = {{20{in_ins[31]}}, in_ins[31:20]};
          dec_fmt = FMT_I;
        end
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        raw_imm = {{20{in_ins[31]}}, in_ins[31:20]};
        dec_fmt = FMT_I;
      end
      7'b0100011: begin
        raw_imm = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
        dec_fmt = FMT_S;
      end
      7'b1100011: begin
        raw_imm = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
        dec_fmt = FMT_B;
        is_bj   = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        raw_imm = {in_ins[31:12], 12'b0};
        dec_fmt = FMT_U;
      end
      7'b1101111: begin
        raw_imm = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0};
        dec_fmt = FMT_J;
        is_bj   = 1'b1;
      end
      default: begin
        raw_imm = '0;
        dec_fmt = FMT_NONE;
      end
    endcase
    wide_imm = XLEN'($signed(raw_imm));
    dec_imm  = (LEGACY_BSHIFT && is_bj) ? (wide_imm >>> 1) : wide_imm;
  end

  logic [XLEN-1:0]  mem_imm [2];
  logic [2:0]       mem_fmt [2];
  logic [TAG_W-1:0] mem_tag [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             accept;
  logic             pop;

  assign in_ready  = !reset && (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // storage is never cleared, so outputs are masked while the buffer is empty
  assign out_imm = out_valid ? mem_imm[rd_ptr] : '0;
  assign out_fmt = out_valid ? mem_fmt[rd_ptr] : FMT_NONE;
  assign out_tag = out_valid ? mem_tag[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (accept) begin
        mem_imm[wr_ptr] <= dec_imm;
        mem_fmt[wr_ptr] <= dec_fmt;
        mem_tag[wr_ptr] <= in_tag;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (accept && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !accept) begin
        count <= count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - vectors, stall/flush/reset sequences and random traffic vs a reference model
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_ins;
  logic [7:0]  in_tag;
  logic        in_ready, out_valid;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic [7:0]  out_tag;
  logic        in_ready2, out_valid2;
  logic [31:0] out_imm2;
  logic [2:0]  out_fmt2;
  logic [7:0]  out_tag2;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .LEGACY_BSHIFT(1'b0)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .LEGACY_BSHIFT(1'b1)) dut2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_ins(in_ins), .in_tag(in_tag),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_imm(out_imm2), .out_fmt(out_fmt2), .out_tag(out_tag2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [63:0] imm;
    logic [31:0] imm2;
    logic [2:0]  fmt;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [31:0] imm2;
    logic [2:0]  fmt;
    logic [7:0]  tag;
  } ent_t;

  vec_t vecs[10];
  ent_t q[$];

  // Reference decode: fields weighted by their bit position, negative offset applied when the sign bit is set
  function automatic void ref_decode(input logic [31:0] ins, output logic [63:0] i64,
                                     output logic [31:0] i32, output logic [2:0] fmt);
    longint v, v2;
    v   = 0;
    fmt = 3'd0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin
        if (ins[6:0] == 7'h13 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)) begin
          fmt = 3'd6;
        end else begin
          fmt = 3'd1;
          v = longint'(ins[30:20]);
          if (ins[31]) v -= 2048;
        end
      end
      7'h23: begin
        fmt = 3'd2;
        v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
        if (ins[31]) v -= 2048;
      end
      7'h63: begin
        fmt = 3'd3;
        v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (ins[31]) v -= 4096;
      end
      7'h37, 7'h17: begin
        fmt = 3'd4;
        v = longint'(ins[30:12]) * 4096;
        if (ins[31]) v -= 64'sh8000_0000;
      end
      7'h6F: begin
        fmt = 3'd5;
        v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (ins[31]) v -= 1048576;
      end
      default: v = 0;
    endcase
    v2 = (fmt == 3'd3 || fmt == 3'd5) ? v / 2 : v;
    if (fmt == 3'd6) begin
      i64 = 64'(ins[25:20]);
      i32 = 32'(ins[24:20]);
    end else begin
      i64 = v;
      i32 = v2[31:0];
    end
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [6:0]  ops [11];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  task automatic check_out(input string pfx);
    if (q.size() == 0) begin
      chk({pfx, "_valid"}, out_valid, 1'b0);
      chk({pfx, "_valid2"}, out_valid2, 1'b0);
      chk({pfx, "_imm_empty"}, out_imm, 64'd0);
    end else begin
      chk({pfx, "_valid"}, out_valid, 1'b1);
      chk({pfx, "_valid2"}, out_valid2, 1'b1);
      chk({pfx, "_imm"}, out_imm, q[0].imm);
      chk({pfx, "_imm2"}, out_imm2, q[0].imm2);
      chk({pfx, "_fmt"}, out_fmt, q[0].fmt);
      chk({pfx, "_fmt2"}, out_fmt2, q[0].fmt);
      chk({pfx, "_tag"}, out_tag, q[0].tag);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [7:0] tag);
    in_valid = v;
    in_ins   = ins;
    in_tag   = tag;
  endtask

  initial begin
    ent_t e;
    logic acc, pop;

    vecs[0] = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1};
    vecs[1] = '{32'h00112423, 64'd8, 32'd8, 3'd2};
    vecs[2] = '{32'h123450B7, 64'h1234_5000, 32'h1234_5000, 3'd4};
    vecs[3] = '{32'h001000EF, 64'h800, 32'h400, 3'd5};
    vecs[4] = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFE, 3'd3};
    vecs[5] = '{32'h00000033, 64'd0, 32'd0, 3'd0};
    vecs[6] = '{32'h03F09093, 64'd63, 32'd31, 3'd6};
    vecs[7] = '{32'h43F0D093, 64'd63, 32'd31, 3'd6};
    vecs[8] = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 3'd4};
    vecs[9] = '{32'h80000067, 64'hFFFF_FFFF_FFFF_F800, 32'hFFFF_F800, 3'd1};

    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 8'h11);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_imm", out_imm, 64'd0);
    chk("rst_out_tag", out_tag, 8'd0);

    // Single-instruction vectors: one-cycle latency from an empty buffer
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, vecs[i].ins, 8'(i + 1));
      #1;
      chk("vec_pre_valid", out_valid, 1'b0);
      chk("vec_in_ready", in_ready, 1'b1);
      @(negedge clk);
      drive(1'b0, 32'h0, 8'h0);
      #1;
      chk("vec_valid", out_valid, 1'b1);
      chk("vec_imm", out_imm, vecs[i].imm);
      chk("vec_imm_legacy32", out_imm2, vecs[i].imm2);
      chk("vec_fmt", out_fmt, vecs[i].fmt);
      chk("vec_tag", out_tag, 8'(i + 1));
    end
    @(negedge clk);
    #1;
    chk("vec_drained", out_valid, 1'b0);

    // Stall: A,B fill the buffer, C waits, then all drain in order
    out_ready = 1'b0;
    drive(1'b1, 32'h00112423, 8'hA0);
    @(negedge clk);
    drive(1'b1, 32'h123450B7, 8'hB0);
    #1;
    chk("stall_a_tag", out_tag, 8'hA0);
    @(negedge clk);
    drive(1'b1, 32'h001000EF, 8'hC0);
    #1;
    chk("stall_full_in_ready", in_ready, 1'b0);
    chk("stall_a_tag2", out_tag, 8'hA0);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("stall_hold_in_ready", in_ready, 1'b0);
    chk("stall_hold_tag", out_tag, 8'hA0);
    chk("stall_hold_imm", out_imm, 64'd8);
    @(negedge clk);
    #1;
    chk("drain_b_tag", out_tag, 8'hB0);
    chk("drain_b_imm", out_imm, 64'h1234_5000);
    chk("drain_in_ready", in_ready, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 8'h0);
    #1;
    chk("drain_c_tag", out_tag, 8'hC0);
    chk("drain_c_imm", out_imm, 64'h800);
    @(negedge clk);
    #1;
    chk("drain_empty", out_valid, 1'b0);

    // Flush with a full buffer and a pending input
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 8'h01);
    @(negedge clk);
    drive(1'b1, 32'hFFF00093, 8'h02);
    @(negedge clk);
    drive(1'b1, 32'h00112423, 8'hDD);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    #1;
    chk("flush_full_valid", out_valid, 1'b0);
    chk("flush_full_in_ready", in_ready, 1'b1);
    // Flush with one entry while an accept happens the same cycle
    drive(1'b1, 32'hFFF00093, 8'h03);
    @(negedge clk);
    drive(1'b1, 32'h00112423, 8'hEE);
    flush = 1'b1;
    #1;
    chk("flush_one_in_ready", in_ready, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    #1;
    chk("flush_acc_valid", out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("flush_acc_never", out_valid, 1'b0);

    // Reset mid-stream with one buffered entry, then resume
    drive(1'b1, 32'hFFF00093, 8'h44);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 32'h00112423, 8'h55);
    #1;
    chk("midrst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_imm", out_imm, 64'd0);
    chk("midrst_fmt", out_fmt, 3'd0);
    chk("midrst_tag", out_tag, 8'd0);
    out_ready = 1'b1;
    drive(1'b1, 32'hFE000EE3, 8'h66);
    @(negedge clk);
    drive(1'b1, 32'h123450B7, 8'h77);
    #1;
    chk("resume_x_tag", out_tag, 8'h66);
    chk("resume_x_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("resume_x_imm2", out_imm2, 32'hFFFF_FFFE);
    @(negedge clk);
    drive(1'b0, 32'h0, 8'h0);
    #1;
    chk("resume_y_tag", out_tag, 8'h77);
    chk("resume_y_fmt", out_fmt, 3'd4);
    @(negedge clk);
    #1;
    chk("resume_empty", out_valid, 1'b0);

    // Random traffic against the queue model
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_ins    = rand_ins();
      in_tag    = 8'($urandom);
      #1;
      chk("rnd_in_ready", in_ready, (q.size() < 2));
      chk("rnd_in_ready2", in_ready2, (q.size() < 2));
      check_out("rnd");
      acc = in_valid && (q.size() < 2);
      pop = (q.size() != 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          ref_decode(in_ins, e.imm, e.imm2, e.fmt);
          e.tag = in_tag;
          q.push_back(e);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
